// File: rtl/stack_sequencer.sv
// Stack-machine command sequencer: expands one accepted command into stack ops
// (binary ALU ops run as POP then REPLACE) and cross-checks the stack's status.
module stack_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [1:0]       stk_op,
    output logic [WIDTH-1:0] stk_data,
    input  logic [WIDTH-1:0] stk_tos,
    input  logic [1:0]       stk_status,
    output logic             done,
    output logic [1:0]       err,
    output logic [DEPTH:0]   depth
);

    typedef enum logic [2:0] {
        CMD_PUSHI, CMD_DROP, CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_XOR, CMD_EQZ
    } cmd_e;

    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} stk_op_e;

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_POP, S_GETA, S_ISSUE, S_CHECK} state_e;

    localparam logic [1:0]     ST_NONE  = 2'd0;
    localparam logic [1:0]     ST_EMPTY = 2'd1;
    localparam logic [DEPTH:0] CAPACITY = '1;
    localparam logic [DEPTH:0] ONE      = (DEPTH+1)'(1);
    localparam logic [DEPTH:0] TWO      = (DEPTH+1)'(2);

    state_e           state, next_state;
    cmd_e             op_reg;
    cmd_e             op_in;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] alu_result;
    logic [1:0]       err_code;
    logic             exp_empty;
    logic             accept;
    logic             legal;
    logic             binary;

    assign op_in  = cmd_e'(cmd_op);
    assign accept = (state == S_IDLE) && cmd_valid;

    always_comb begin
        legal  = 1'b0;
        binary = 1'b0;
        case (op_in)
            CMD_PUSHI:         legal = (depth != CAPACITY);
            CMD_DROP, CMD_EQZ: legal = (depth >= ONE);
            default: begin
                legal  = (depth >= TWO);
                binary = 1'b1;
            end
        endcase
    end

    // A is the deeper operand, now on top after the POP; B was captured at accept
    always_comb begin
        alu_result = '0;
        case (op_reg)
            CMD_ADD: alu_result = stk_tos + b_reg;
            CMD_SUB: alu_result = stk_tos - b_reg;
            CMD_AND: alu_result = stk_tos & b_reg;
            CMD_OR:  alu_result = stk_tos | b_reg;
            CMD_XOR: alu_result = stk_tos ^ b_reg;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!legal)      next_state = S_ERR;
                    else if (binary) next_state = S_POP;
                    else             next_state = S_ISSUE;
                end
            end
            S_ERR:   next_state = S_IDLE;
            S_POP:   next_state = S_GETA;
            S_GETA:  next_state = S_ISSUE;
            S_ISSUE: next_state = S_CHECK;
            S_CHECK: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        done      = 1'b0;
        err       = 2'd0;
        case (state)
            S_ERR: err = err_code;
            S_CHECK: begin
                if (stk_status == (exp_empty ? ST_EMPTY : ST_NONE)) done = 1'b1;
                else                                                 err  = 2'd3;
            end
            default: ;
        endcase
    end

    // stk_op is loaded one edge ahead so it is live during POP/ISSUE states
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stk_op    <= OP_NONE;
            stk_data  <= '0;
            depth     <= '0;
            op_reg    <= CMD_PUSHI;
            b_reg     <= '0;
            err_code  <= 2'd0;
            exp_empty <= 1'b0;
        end else begin
            stk_op <= OP_NONE;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_reg    <= op_in;
                        b_reg     <= stk_tos;
                        exp_empty <= 1'b0;
                        err_code  <= (op_in == CMD_PUSHI) ? 2'd2 : 2'd1;
                        if (legal) begin
                            case (op_in)
                                CMD_PUSHI: begin
                                    stk_op   <= OP_PUSH;
                                    stk_data <= cmd_imm;
                                    depth    <= depth + ONE;
                                end
                                CMD_DROP: begin
                                    stk_op    <= OP_POP;
                                    depth     <= depth - ONE;
                                    exp_empty <= (depth == ONE);
                                end
                                CMD_EQZ: begin
                                    stk_op   <= OP_REPLACE;
                                    stk_data <= WIDTH'(stk_tos == '0);
                                end
                                default: begin
                                    stk_op <= OP_POP;
                                    depth  <= depth - ONE;
                                end
                            endcase
                        end
                    end
                end
                S_GETA: begin
                    stk_op   <= OP_REPLACE;
                    stk_data <= alu_result;
                end
                default: ;
            endcase
        end
    end

endmodule
